rand_index_gen_nch: RTL

Parametrised, multi-channel successor to the two-output LFSR index generator. It produces sets of `NUM_IDX` pairwise-distinct random indices, each in `[0, idx_bound)`, from a reloadable Galois LFSR. Results are delivered over a valid/ready handshake so downstream address logic can apply backpressure. It sits in front of the sampling/addressing datapath wherever random memory indices are consumed.

---
 rtl/rand_index_gen_nch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rand_index_gen_nch.sv
// Random index-set generator: draws NUM_IDX pairwise-distinct indices below a bound
// from a reloadable Galois LFSR and presents each set on a valid/ready output.
module rand_index_gen_nch #(
  parameter int                    ADDR_BITWIDTH = 8,
  parameter int                    NUM_IDX       = 2,
  parameter int                    LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 16'hB400,
  parameter int                    SEED_BITWIDTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ena,
  input  logic                             seed_load,
  input  logic [SEED_BITWIDTH-1:0]         seed_dis,
  input  logic [ADDR_BITWIDTH:0]           idx_bound,
  output logic [NUM_IDX*ADDR_BITWIDTH-1:0] idx_vec,
  output logic                             idx_valid,
  input  logic                             idx_ready,
  output logic                             err,
  output logic [1:0]                       state_dbg
);

  // Handshake: a set transfers on any rising edge where idx_valid && idx_ready.
  // Once raised, idx_valid and idx_vec hold until that transfer, reset or seed_load.

  localparam int CW = $clog2(NUM_IDX + 1);
  localparam logic [CW-1:0]            LAST       = CW'(NUM_IDX - 1);
  localparam logic [ADDR_BITWIDTH:0]   FULL_BOUND = {1'b1, {ADDR_BITWIDTH{1'b0}}};
  localparam logic [ADDR_BITWIDTH:0]   NUM_IDX_B  = (ADDR_BITWIDTH + 1)'(NUM_IDX);
  localparam logic [LFSR_WIDTH-1:0]    LFSR_RST   =
    {{(LFSR_WIDTH - SEED_BITWIDTH){1'b1}}, {SEED_BITWIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [LFSR_WIDTH-1:0]    lfsr_q, lfsr_d, lfsr_next, lfsr_seeded;
  logic [ADDR_BITWIDTH-1:0] slot_q [NUM_IDX];
  logic [ADDR_BITWIDTH-1:0] slot_d [NUM_IDX];
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [ADDR_BITWIDTH:0]   bound_q, bound_d;
  logic                     err_q, err_d;
  logic [ADDR_BITWIDTH:0]   eff_bound;
  logic [ADDR_BITWIDTH-1:0] cand;
  logic                     cand_ok;
  logic                     bound_bad;

  assign lfsr_next   = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
  assign lfsr_seeded = {{(LFSR_WIDTH - SEED_BITWIDTH){1'b1}}, seed_dis};
  assign cand        = lfsr_q[ADDR_BITWIDTH-1:0];
  assign eff_bound   = (idx_bound == '0) ? FULL_BOUND : idx_bound;
  assign bound_bad   = eff_bound < NUM_IDX_B;

  // Only slots below the counter take part in the distinctness check.
  always_comb begin
    cand_ok = ({1'b0, cand} < bound_q);
    for (int k = 0; k < NUM_IDX; k++) begin
      if ((CW'(k) < cnt_q) && (slot_q[k] == cand)) cand_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    bound_d = bound_q;
    err_d   = err_q;
    if (seed_load) begin
      lfsr_d  = lfsr_seeded;
      state_d = S_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
      for (int k = 0; k < NUM_IDX; k++) slot_d[k] = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          err_d = ena && bound_bad;
          if (ena && !bound_bad) begin
            state_d = S_DRAW;
            bound_d = eff_bound;
            cnt_d   = '0;
            for (int k = 0; k < NUM_IDX; k++) slot_d[k] = '0;
          end
        end
        S_DRAW: begin
          if (ena) begin
            lfsr_d = lfsr_next;
            if (cand_ok) begin
              for (int k = 0; k < NUM_IDX; k++) begin
                if (CW'(k) == cnt_q) slot_d[k] = cand;
              end
              cnt_d = cnt_q + CW'(1);
              if (cnt_q == LAST) state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (idx_ready) begin
            cnt_d = '0;
            for (int k = 0; k < NUM_IDX; k++) slot_d[k] = '0;
            if (ena) begin
              state_d = S_DRAW;
              bound_d = eff_bound;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_RST;
      cnt_q   <= '0;
      bound_q <= FULL_BOUND;
      err_q   <= 1'b0;
      for (int k = 0; k < NUM_IDX; k++) slot_q[k] <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      bound_q <= bound_d;
      err_q   <= err_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_IDX; k++) idx_vec[k*ADDR_BITWIDTH +: ADDR_BITWIDTH] = slot_q[k];
  end

  assign idx_valid = (state_q == S_HOLD);
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule
